// File: rtl/uart_core.sv
// Full-duplex UART: fixed-rate transmitter plus a 16x-oversampling receiver with
// majority-vote bit sampling, parity/stop checking and overrun detection.
module uart_core #(
  parameter int BAUD_DIV  = 163,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 txd_out,
  output logic                 busy,
  input  logic                 rxd_in,
  input  logic                 read,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 new_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_CLKS = 16 * BAUD_DIV;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int DIVW     = $clog2(BAUD_DIV + 1);
  localparam logic [TW-1:0]   BIT_LAST  = TW'(BIT_CLKS - 1);
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(BAUD_DIV - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            HAS_PAR   = (PARITY != 0);
  localparam logic            ODD_PAR   = (PARITY == 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           tx_state_reg;
  logic [TW-1:0]        tx_timer_reg;
  logic [3:0]           tx_idx_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 txd_reg;
  logic                 busy_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg <= S_IDLE;
      tx_timer_reg <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (tx_state_reg)
        S_IDLE: begin
          if (load) begin
            tx_shift_reg <= data_in;
            tx_par_reg   <= (^data_in) ^ ODD_PAR;
            tx_state_reg <= S_START;
            tx_timer_reg <= '0;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        default: begin
          if (tx_timer_reg != BIT_LAST) begin
            tx_timer_reg <= tx_timer_reg + 1'b1;
          end else begin
            tx_timer_reg <= '0;
            case (tx_state_reg)
              S_START: begin
                tx_state_reg <= S_DATA;
                tx_idx_reg   <= '0;
                txd_reg      <= tx_shift_reg[0];
              end
              S_DATA: begin
                if (tx_idx_reg == DATA_LAST) begin
                  tx_idx_reg   <= '0;
                  tx_state_reg <= HAS_PAR ? S_PARITY : S_STOP;
                  txd_reg      <= HAS_PAR ? tx_par_reg : 1'b1;
                end else begin
                  tx_idx_reg   <= tx_idx_reg + 1'b1;
                  tx_shift_reg <= tx_shift_reg >> 1;
                  txd_reg      <= tx_shift_reg[1];
                end
              end
              S_PARITY: begin
                tx_state_reg <= S_STOP;
                txd_reg      <= 1'b1;
              end
              S_STOP: begin
                if (tx_idx_reg == STOP_LAST) begin
                  tx_state_reg <= S_IDLE;
                  busy_reg     <= 1'b0;
                end else begin
                  tx_idx_reg <= tx_idx_reg + 1'b1;
                end
              end
              default: begin
                tx_state_reg <= S_IDLE;
                busy_reg     <= 1'b0;
                txd_reg      <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  logic [DIVW-1:0]      div_reg;
  logic                 rx_meta_reg;
  logic                 rx_sync_reg;
  logic [2:0]           rx_state_reg;
  logic [3:0]           rx_tick_reg;
  logic [3:0]           rx_idx_reg;
  logic [1:0]           samp_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 par_acc_reg;
  logic                 ferr_reg;
  logic [DATA_BITS-1:0] data_out_reg;
  logic                 new_data_reg;
  logic                 parity_err_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;
  logic                 tick;
  logic                 maj;

  assign tick = (div_reg == DIV_LAST);
  // samp_reg holds ticks 7 and 8; the live synchronised value is the tick-9 sample
  assign maj  = (samp_reg[0] & samp_reg[1]) | (rx_sync_reg & (samp_reg[0] | samp_reg[1]));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg        <= '0;
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_state_reg   <= S_IDLE;
      rx_tick_reg    <= '0;
      rx_idx_reg     <= '0;
      samp_reg       <= 2'b11;
      rx_shift_reg   <= '0;
      par_acc_reg    <= 1'b0;
      ferr_reg       <= 1'b0;
      data_out_reg   <= '0;
      new_data_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      rx_meta_reg <= rxd_in;
      rx_sync_reg <= rx_meta_reg;
      div_reg     <= tick ? '0 : div_reg + 1'b1;
      if (read) begin
        new_data_reg   <= 1'b0;
        parity_err_reg <= 1'b0;
        frame_err_reg  <= 1'b0;
        overrun_reg    <= 1'b0;
      end
      case (rx_state_reg)
        S_IDLE: begin
          if (!rx_sync_reg) begin
            rx_state_reg <= S_START;
            rx_tick_reg  <= '0;
            rx_idx_reg   <= '0;
            par_acc_reg  <= 1'b0;
            ferr_reg     <= 1'b0;
          end
        end
        default: begin
          if (tick) begin
            rx_tick_reg <= rx_tick_reg + 1'b1;
            if (rx_tick_reg == 4'd7) samp_reg[0] <= rx_sync_reg;
            if (rx_tick_reg == 4'd8) samp_reg[1] <= rx_sync_reg;
            if (rx_tick_reg == 4'd9) begin
              case (rx_state_reg)
                S_START: if (maj) rx_state_reg <= S_IDLE;
                S_DATA: begin
                  rx_shift_reg <= {maj, rx_shift_reg[DATA_BITS-1:1]};
                  par_acc_reg  <= par_acc_reg ^ maj;
                end
                S_PARITY: par_acc_reg <= par_acc_reg ^ maj;
                S_STOP: begin
                  // Complete at mid final stop bit so a back-to-back start edge is not missed
                  if (rx_idx_reg == STOP_LAST) begin
                    data_out_reg   <= rx_shift_reg;
                    new_data_reg   <= 1'b1;
                    parity_err_reg <= HAS_PAR & (par_acc_reg ^ ODD_PAR);
                    frame_err_reg  <= ferr_reg | ~maj;
                    overrun_reg    <= new_data_reg & ~read;
                    rx_state_reg   <= S_IDLE;
                  end else begin
                    ferr_reg <= ferr_reg | ~maj;
                  end
                end
                default: ;
              endcase
            end
            if (rx_tick_reg == 4'd15) begin
              case (rx_state_reg)
                S_START: begin
                  rx_state_reg <= S_DATA;
                  rx_idx_reg   <= '0;
                end
                S_DATA: begin
                  if (rx_idx_reg == DATA_LAST) begin
                    rx_idx_reg   <= '0;
                    rx_state_reg <= HAS_PAR ? S_PARITY : S_STOP;
                  end else begin
                    rx_idx_reg <= rx_idx_reg + 1'b1;
                  end
                end
                S_PARITY: rx_state_reg <= S_STOP;
                S_STOP:   rx_idx_reg   <= rx_idx_reg + 1'b1;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign txd_out    = txd_reg;
  assign busy       = busy_reg;
  assign data_out   = data_out_reg;
  assign new_data   = new_data_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: four instances covering default loopback, fast loopback,
// bench-driven even-parity receive, and a 7-bit/odd/2-stop loopback.
module tb_uart_core;

  localparam int BT  = 64;        // bit time of the BAUD_DIV=4 instances
  localparam int BT0 = 16 * 163;  // bit time of the default instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int failures = 0;

  logic l0, r0, t0, b0, nd0, pe0, fe0, ov0;
  logic [7:0] di0, do0;
  logic l1, r1, t1, b1, nd1, pe1, fe1, ov1;
  logic [7:0] di1, do1;
  logic l2, r2, rx2, t2, b2, nd2, pe2, fe2, ov2;
  logic [7:0] di2, do2;
  logic l3, r3, t3, b3, nd3, pe3, fe3, ov3;
  logic [6:0] di3, do3;

  uart_core u0 (
    .clk(clk), .rst(rst), .load(l0), .data_in(di0), .txd_out(t0), .busy(b0),
    .rxd_in(t0), .read(r0), .data_out(do0), .new_data(nd0), .parity_err(pe0),
    .frame_err(fe0), .overrun(ov0)
  );

  uart_core #(.BAUD_DIV(4)) u1 (
    .clk(clk), .rst(rst), .load(l1), .data_in(di1), .txd_out(t1), .busy(b1),
    .rxd_in(t1), .read(r1), .data_out(do1), .new_data(nd1), .parity_err(pe1),
    .frame_err(fe1), .overrun(ov1)
  );

  uart_core #(.BAUD_DIV(4), .PARITY(2)) u2 (
    .clk(clk), .rst(rst), .load(l2), .data_in(di2), .txd_out(t2), .busy(b2),
    .rxd_in(rx2), .read(r2), .data_out(do2), .new_data(nd2), .parity_err(pe2),
    .frame_err(fe2), .overrun(ov2)
  );

  uart_core #(.BAUD_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .load(l3), .data_in(di3), .txd_out(t3), .busy(b3),
    .rxd_in(t3), .read(r3), .data_out(do3), .new_data(nd3), .parity_err(pe3),
    .frame_err(fe3), .overrun(ov3)
  );

  // Serial frame on u2's line: start, 8 data LSB first, parity, stop, then one idle bit.
  task automatic send_rx2(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx2 = f[k];
      repeat (BT) @(negedge clk);
    end
    rx2 = 1'b1;
    repeat (BT) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {l0, r0, l1, r1, l2, r2, l3, r3} = '0;
    di0 = '0; di1 = '0; di2 = '0; di3 = '0;
    rx2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({t0, b0, nd0, pe0, fe0, ov0, do0} !== {6'b100000, 8'h00}) begin
      failures++;
      $display("FAIL reset_u0 got=%b want=%b", {t0, b0, nd0, pe0, fe0, ov0, do0}, {6'b100000, 8'h00});
    end
    checks++;
    if ({t1, b1, nd1, pe1, fe1, ov1, do1} !== {6'b100000, 8'h00}) begin
      failures++;
      $display("FAIL reset_u1 got=%b want=%b", {t1, b1, nd1, pe1, fe1, ov1, do1}, {6'b100000, 8'h00});
    end
    checks++;
    if ({nd2, pe2, fe2, ov2, do2, t3, b3, nd3, do3} !== {4'b0000, 8'h00, 3'b100, 7'h00}) begin
      failures++;
      $display("FAIL reset_u2u3 got=%b want=%b", {nd2, pe2, fe2, ov2, do2, t3, b3, nd3, do3},
               {4'b0000, 8'h00, 3'b100, 7'h00});
    end
  endtask

  task automatic test_loopback_default();
    int busy_cnt, low_cnt;
    logic seen_high;
    busy_cnt = 0; low_cnt = 0; seen_high = 1'b0;
    @(negedge clk); di0 = 8'hB9; l0 = 1'b1;
    @(negedge clk); l0 = 1'b0; di0 = 8'h00;
    checks++;
    if ({b0, t0} !== 2'b10) begin
      failures++;
      $display("FAIL default_start got=%b want=10", {b0, t0});
    end
    for (int i = 0; i < 30000 && b0 === 1'b1; i++) begin
      if (t0 === 1'b0 && !seen_high) low_cnt++;
      else seen_high = 1'b1;
      busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (low_cnt != BT0) begin
      failures++;
      $display("FAIL default_start_len got=%0d want=%0d", low_cnt, BT0);
    end
    checks++;
    if (busy_cnt != 10 * BT0) begin
      failures++;
      $display("FAIL default_frame_len got=%0d want=%0d", busy_cnt, 10 * BT0);
    end
    checks++;
    if ({nd0, pe0, fe0, ov0, do0} !== {4'b1000, 8'hB9}) begin
      failures++;
      $display("FAIL default_rx got=%h want=%h", {nd0, pe0, fe0, ov0, do0}, {4'b1000, 8'hB9});
    end
    r0 = 1'b1; @(negedge clk); r0 = 1'b0;
    checks++;
    if ({nd0, do0} !== {1'b0, 8'hB9}) begin
      failures++;
      $display("FAIL default_read got=%h want=%h", {nd0, do0}, {1'b0, 8'hB9});
    end
  endtask

  task automatic test_load_held();
    int low;
    @(negedge clk); di1 = 8'hB9; l1 = 1'b1;
    @(negedge clk); di1 = 8'h8E;
    for (int i = 0; i < 2000 && b1 === 1'b1; i++) @(negedge clk);
    checks++;
    if ({nd1, ov1, do1} !== {2'b10, 8'hB9}) begin
      failures++;
      $display("FAIL held_first got=%h want=%h", {nd1, ov1, do1}, {2'b10, 8'hB9});
    end
    low = 0;
    for (int i = 0; i < 10 && b1 !== 1'b1; i++) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 1) begin
      failures++;
      $display("FAIL held_gap got=%0d want=1", low);
    end
    l1 = 1'b0;
    for (int i = 0; i < 2000 && b1 === 1'b1; i++) @(negedge clk);
    checks++;
    if ({nd1, ov1, do1} !== {2'b11, 8'h8E}) begin
      failures++;
      $display("FAIL held_second got=%h want=%h", {nd1, ov1, do1}, {2'b11, 8'h8E});
    end
    r1 = 1'b1; @(negedge clk); r1 = 1'b0;
    checks++;
    if ({nd1, pe1, fe1, ov1} !== 4'b0000) begin
      failures++;
      $display("FAIL held_read got=%b want=0000", {nd1, pe1, fe1, ov1});
    end
  endtask

  task automatic test_random_loopback();
    logic [7:0] d;
    logic [9:0] frame;
    int bad;
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      frame = {1'b1, d, 1'b0};
      bad = 0;
      @(negedge clk); di1 = d; l1 = 1'b1;
      @(negedge clk); l1 = 1'b0;
      repeat (BT / 2 - 1) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        if (t1 !== frame[k]) bad++;
        repeat (BT) @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_tx_bits data=%h bad_bits=%0d want=0", d, bad);
      end
      checks++;
      if ({nd1, pe1, fe1, ov1, b1, do1} !== {5'b10000, d}) begin
        failures++;
        $display("FAIL rand_loop_rx got=%h want=%h", {nd1, pe1, fe1, ov1, b1, do1}, {5'b10000, d});
      end
      r1 = 1'b1; @(negedge clk); r1 = 1'b0;
    end
  endtask

  task automatic test_parity_error();
    @(negedge clk);
    send_rx2(8'h01, 1'b0, 1'b1);
    checks++;
    if ({nd2, pe2, fe2, ov2, do2} !== {4'b1100, 8'h01}) begin
      failures++;
      $display("FAIL parity_err got=%h want=%h", {nd2, pe2, fe2, ov2, do2}, {4'b1100, 8'h01});
    end
    r2 = 1'b1; @(negedge clk); r2 = 1'b0;
    checks++;
    if ({nd2, pe2, fe2, ov2, do2} !== {4'b0000, 8'h01}) begin
      failures++;
      $display("FAIL parity_read got=%h want=%h", {nd2, pe2, fe2, ov2, do2}, {4'b0000, 8'h01});
    end
  endtask

  task automatic test_frame_error_glitch();
    send_rx2(8'h55, 1'b0, 1'b0);
    checks++;
    if ({nd2, pe2, fe2, ov2, do2} !== {4'b1010, 8'h55}) begin
      failures++;
      $display("FAIL frame_err got=%h want=%h", {nd2, pe2, fe2, ov2, do2}, {4'b1010, 8'h55});
    end
    r2 = 1'b1; @(negedge clk); r2 = 1'b0;
    rx2 = 1'b0;
    repeat (24) @(negedge clk);
    rx2 = 1'b1;
    repeat (12 * BT) @(negedge clk);
    checks++;
    if ({nd2, pe2, fe2, ov2} !== 4'b0000) begin
      failures++;
      $display("FAIL glitch_flags got=%b want=0000", {nd2, pe2, fe2, ov2});
    end
    send_rx2(8'hC3, 1'b0, 1'b1);
    checks++;
    if ({nd2, pe2, fe2, ov2, do2} !== {4'b1000, 8'hC3}) begin
      failures++;
      $display("FAIL after_glitch got=%h want=%h", {nd2, pe2, fe2, ov2, do2}, {4'b1000, 8'hC3});
    end
    r2 = 1'b1; @(negedge clk); r2 = 1'b0;
  endtask

  task automatic test_random_rx();
    logic [7:0] d;
    logic bp, bs;
    for (int n = 0; n < 8; n++) begin
      d  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      send_rx2(d, (^d) ^ bp, ~bs);
      checks++;
      if ({nd2, pe2, fe2, ov2, do2} !== {1'b1, bp, bs, 1'b0, d}) begin
        failures++;
        $display("FAIL rand_rx got=%h want=%h", {nd2, pe2, fe2, ov2, do2}, {1'b1, bp, bs, 1'b0, d});
      end
      r2 = 1'b1; @(negedge clk); r2 = 1'b0;
    end
  endtask

  task automatic test_long_frame();
    logic [6:0] d;
    int cnt;
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 7'h2A : 7'($urandom_range(0, 127));
      @(negedge clk); di3 = d; l3 = 1'b1;
      @(negedge clk); l3 = 1'b0;
      cnt = 0;
      for (int i = 0; i < 2000 && b3 === 1'b1; i++) begin
        cnt++;
        @(negedge clk);
      end
      checks++;
      if (cnt != 11 * BT) begin
        failures++;
        $display("FAIL long_frame_len data=%h got=%0d want=%0d", d, cnt, 11 * BT);
      end
      checks++;
      if ({nd3, pe3, fe3, ov3, do3} !== {4'b1000, d}) begin
        failures++;
        $display("FAIL long_frame_rx got=%h want=%h", {nd3, pe3, fe3, ov3, do3}, {4'b1000, d});
      end
      r3 = 1'b1; @(negedge clk); r3 = 1'b0;
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    @(negedge clk); di1 = d; l1 = 1'b1;
    @(negedge clk); l1 = 1'b0;
    for (int i = 0; i < 2000 && b1 === 1'b1; i++) @(negedge clk);
    di1 = ~d; l1 = 1'b1;
    @(negedge clk); l1 = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({t1, b1, nd1, do1} !== {3'b100, 8'h00}) begin
      failures++;
      $display("FAIL rst_mid got=%h want=%h", {t1, b1, nd1, do1}, {3'b100, 8'h00});
    end
    repeat (12 * BT) @(negedge clk);
    checks++;
    if ({nd1, pe1, fe1, ov1} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_partial got=%b want=0000", {nd1, pe1, fe1, ov1});
    end
    d = 8'($urandom_range(0, 255));
    di1 = d; l1 = 1'b1;
    @(negedge clk); l1 = 1'b0;
    for (int i = 0; i < 2000 && b1 === 1'b1; i++) @(negedge clk);
    checks++;
    if ({nd1, pe1, fe1, ov1, do1} !== {4'b1000, d}) begin
      failures++;
      $display("FAIL rst_next_frame got=%h want=%h", {nd1, pe1, fe1, ov1, do1}, {4'b1000, d});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_default();
    test_load_held();
    test_random_loopback();
    test_parity_error();
    test_frame_error_glitch();
    test_random_rx();
    test_long_frame();
    test_mid_frame_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
